chunked_adder: RTL
==================

CHUNKED_ADDER -- requirements
Module: chunked_adder

Interface
REQ-001 The module SHALL have parameter BUS_SIZE, default 16, giving the operand and result width in bits.
REQ-002 The module SHALL have parameter CHUNK_SIZE, default 4, giving the bits added per cycle; BUS_SIZE SHALL be an integer multiple of CHUNK_SIZE, otherwise elaboration fails.
REQ-003 The module SHALL have one clock and a synchronous, active-high reset, with these ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  operands presented.
- in_ready  output  1  block can accept operands.
- a, b  input  BUS_SIZE each  unsigned operands.
- c_in  input  1  carry-in.
- sub  input  1  1 = subtract mode.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- out  output  BUS_SIZE  result.
- carry  output  1  final carry-out.
- overflow  output  1  two's-complement overflow.
- zero  output  1  result equals 0.

Function
REQ-004 The block SHALL be an FSM with three states: IDLE, BUSY and DONE; N = BUS_SIZE/CHUNK_SIZE.
REQ-005 IDLE SHALL drive in_ready=1; all other states SHALL drive in_ready=0; only DONE SHALL drive out_valid=1.
REQ-006 The block SHALL accept operands on the edge where in_valid && in_ready: it latches a, b'=(sub ? ~b : b) and c_in, clears chunk counter k, clears the result register, and moves to BUSY.
REQ-007 Each BUSY edge SHALL add chunk k of a and b' plus the stored carry, write the sum into result bits [k*CHUNK_SIZE +: CHUNK_SIZE], store the chunk carry-out, and increment k.
REQ-008 The edge processing chunk N-1 SHALL move the FSM to DONE, so out_valid rises exactly N cycles after the acceptance edge (4 cycles at the defaults).
REQ-009 In DONE, out, carry, overflow and zero SHALL be held stable until out_valid && out_ready; on that edge the FSM SHALL return to IDLE, and in_ready SHALL be 1 in the following cycle.
REQ-010 Operands SHALL be accepted only in IDLE; in_valid in BUSY or DONE SHALL be ignored, and no operation overlaps another.
REQ-011 Arithmetic SHALL be modulo 2^BUS_SIZE: out = a + b' + c_in, and carry = bit BUS_SIZE of that sum. Subtraction is a - b when c_in=1, and carry=1 means no borrow.
REQ-012 overflow SHALL be 1 iff a[MSB]==b'[MSB] and out[MSB]!=a[MSB].
REQ-013 zero SHALL be 1 iff out == 0.
REQ-014 When N=1 (CHUNK_SIZE==BUS_SIZE), the block SHALL complete in one BUSY cycle.
REQ-015 The a, b, c_in and sub inputs SHALL be don't-care outside the acceptance edge.

Reset
REQ-016 While rst is high at a clock edge, the FSM SHALL enter IDLE and k, the result register and the stored carry SHALL clear.
REQ-017 After reset the outputs SHALL be: in_ready=1, out_valid=0, out=0, carry=0, overflow=0, zero=0.
REQ-018 Reset SHALL take priority over every handshake; reset during BUSY or DONE SHALL discard the operation with no out_valid pulse.

Configuration
REQ-019 With macro CHUNKED_ADDER_FLAGS_EN defined, overflow and zero SHALL be computed per REQ-012 and REQ-013 and registered with the result.
REQ-020 Without CHUNKED_ADDER_FLAGS_EN, overflow and zero SHALL be tied to 0, with no flag logic; out, carry and the handshake SHALL be unchanged.

Verification (BUS_SIZE=16, CHUNK_SIZE=4, macro defined unless noted)
REQ-021 The bench SHALL cover:
- a=0xFFFF, b=0x0001, c_in=0, sub=0 -> after 4 cycles out_valid=1, out=0x0000, carry=1, zero=1, overflow=0.
- a=0x7FFF, b=0x0001, c_in=0, sub=0 -> out=0x8000, overflow=1, carry=0, zero=0; without the macro, overflow=0.
- a=0x0005, b=0x0007, c_in=1, sub=1 -> out=0xFFFE, carry=0, overflow=0; then a=0x0007, b=0x0005 -> out=0x0002, carry=1.
- Hold out_ready=0 for 3 cycles in DONE and pulse in_valid -> outputs stay stable, in_ready=0, the new operands are ignored; out_ready=1 -> IDLE next cycle.
- Assert rst on the 2nd BUSY cycle -> next cycle in_ready=1, out_valid=0, out=0; a new add of 0x1234+0x1111 then gives 0x2345.
- BUS_SIZE=32, CHUNK_SIZE=8: a=0xFFFFFFFF, b=0x00000001 -> out_valid after exactly 4 cycles, out=0, carry=1; BUS_SIZE=16 with CHUNK_SIZE=16 gives a 1-cycle latency.

Source files
------------

// File: rtl/chunked_adder.sv
`default_nettype none
// ============================================================================
// Module      : chunked_adder
// Description : Multi-cycle adder/subtractor working CHUNK_SIZE bits per cycle
//               with valid/ready handshakes. Optional flags: CHUNKED_ADDER_FLAGS_EN
// Revision    : 1.0 - initial release
// ============================================================================
module chunked_adder #(
    parameter int BUS_SIZE   = 16,
    parameter int CHUNK_SIZE = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [BUS_SIZE-1:0] a,
    input  logic [BUS_SIZE-1:0] b,
    input  logic                c_in,
    input  logic                sub,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [BUS_SIZE-1:0] out,
    output logic                carry,
    output logic                overflow,
    output logic                zero
);

    localparam int N  = BUS_SIZE / CHUNK_SIZE;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] C_K_LAST = KW'(N - 1);
    localparam int MSB = BUS_SIZE - 1;

    generate
        if ((CHUNK_SIZE < 1) || ((BUS_SIZE % CHUNK_SIZE) != 0)) begin : g_bad_size
            $error("chunked_adder: BUS_SIZE must be a multiple of CHUNK_SIZE");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [KW-1:0]       k_q, k_d;
    logic [BUS_SIZE-1:0] a_q, a_d;
    logic [BUS_SIZE-1:0] b_q, b_d;
    logic [BUS_SIZE-1:0] res_q, res_d;
    logic                carry_q, carry_d;
    logic                in_ready_q, in_ready_d;
    logic                out_valid_q, out_valid_d;
    logic [CHUNK_SIZE:0] w_chunk_sum;
`ifdef CHUNKED_ADDER_FLAGS_EN
    logic                ovf_q, ovf_d;
    logic                zero_q, zero_d;
`endif

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        a_d         = a_q;
        b_d         = b_q;
        res_d       = res_q;
        carry_d     = carry_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
`ifdef CHUNKED_ADDER_FLAGS_EN
        ovf_d       = ovf_q;
        zero_d      = zero_q;
`endif
        w_chunk_sum = {1'b0, a_q[k_q*CHUNK_SIZE +: CHUNK_SIZE]}
                    + {1'b0, b_q[k_q*CHUNK_SIZE +: CHUNK_SIZE]}
                    + {{CHUNK_SIZE{1'b0}}, carry_q};
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    a_d        = a;
                    b_d        = sub ? ~b : b;
                    carry_d    = c_in;
                    k_d        = '0;
                    res_d      = '0;
                    state_d    = BUSY;
                    in_ready_d = 1'b0;
`ifdef CHUNKED_ADDER_FLAGS_EN
                    ovf_d      = 1'b0;
                    zero_d     = 1'b0;
`endif
                end
            end
            BUSY: begin
                res_d[k_q*CHUNK_SIZE +: CHUNK_SIZE] = w_chunk_sum[CHUNK_SIZE-1:0];
                carry_d = w_chunk_sum[CHUNK_SIZE];
                if (k_q == C_K_LAST) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
`ifdef CHUNKED_ADDER_FLAGS_EN
                    // Flags use the fully assembled result including this last chunk
                    ovf_d  = (a_q[MSB] == b_q[MSB]) && (res_d[MSB] != a_q[MSB]);
                    zero_d = (res_d == '0);
`endif
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            k_q         <= '0;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            carry_q     <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef CHUNKED_ADDER_FLAGS_EN
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            a_q         <= a_d;
            b_q         <= b_d;
            res_q       <= res_d;
            carry_q     <= carry_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
`ifdef CHUNKED_ADDER_FLAGS_EN
            ovf_q       <= ovf_d;
            zero_q      <= zero_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out       = res_q;
    assign carry     = carry_q;
`ifdef CHUNKED_ADDER_FLAGS_EN
    assign overflow  = ovf_q;
    assign zero      = zero_q;
`else
    assign overflow  = 1'b0;
    assign zero      = 1'b0;
`endif

endmodule
`default_nettype wire
